buffer2axis: RTL and testbench
==============================

Name: buffer2axis

Overview:
- Downstream neighbour of the AXIS-to-row-buffer stage, sitting after the conware computation.
- Accepts one WIDTH-bit row of cell states (1 = alive, 0 = dead) over a valid/ready handshake.
- Serialises that row into WIDTH pixels on an AXI-Stream master, mapping each bit to alive_color or dead_color.
- Asserts TLAST on the final pixel of the final row of each frame, so VDMA/DMA sees frame boundaries.

Parameters:
- DWIDTH, 32: pixel width on M_AXIS_TDATA and width of the colour inputs.
- WIDTH, 8: cells per row, i.e. bits per in_data word. Range 2..256.
- HEIGHT, 8: rows per frame; sets TLAST placement. Range 1..256.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  reset; asynchronous assert, active-low.
- alive_color  in  DWIDTH  pixel value emitted for bit = 1.
- dead_color  in  DWIDTH  pixel value emitted for bit = 0.
- in_data  in  WIDTH  row of cell states; bit 0 is the first pixel sent.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a row (registered).
- M_AXIS_TDATA  out  DWIDTH  pixel data.
- M_AXIS_TVALID  out  1  pixel valid (registered).
- M_AXIS_TREADY  in  1  sink accepts pixel.
- M_AXIS_TLAST  out  1  last pixel of frame.

Behaviour:
- Reset (rstn low, async): state=Idle, in_ready=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, pixel counter=0, row counter=0, row and colour registers=0.
- First rising clk after rstn deasserts: in_ready becomes 1.
- State Idle:
  - in_ready=1, M_AXIS_TVALID=0.
  - On in_valid&&in_ready at edge N: latch in_data into the row register and latch alive_color/dead_color; pixel counter=0; state goes to Send.
  - At N+1: in_ready=0, M_AXIS_TVALID=1, first pixel driven.
- State Send:
  - M_AXIS_TVALID=1, in_ready=0.
  - M_AXIS_TDATA = row[pixel counter] ? latched alive : latched dead.
  - Colour changes on the inputs mid-row have no effect until the next row is accepted.
  - M_AXIS_TLAST=1 exactly when pixel counter==WIDTH-1 and row counter==HEIGHT-1; otherwise 0.
  - On TVALID&&TREADY with pixel counter<WIDTH-1: counter increments.
  - On TVALID&&TREADY with pixel counter==WIDTH-1: counter goes to 0; row counter increments, or wraps to 0 if it was HEIGHT-1; state returns to Idle and in_ready=1 next cycle.
- AXIS rules:
  - While TVALID=1 and TREADY=0, TDATA, TLAST and TVALID hold stable.
  - TVALID never drops without a handshake.
  - TREADY held low indefinitely stalls the block with no loss.
- Throughput: WIDTH+1 cycles per row at full TREADY; one Idle cycle between rows is by design.
- in_valid while in_ready=0 is ignored; the upstream holds its data per the handshake.
- HEIGHT=1: TLAST fires on the last pixel of every row.
- Counter widths: pixel counter $clog2(WIDTH), row counter $clog2(HEIGHT), minimum 1 bit each. Wrap compares explicitly against WIDTH-1 and HEIGHT-1, never natural overflow.
- Reset mid-row or mid-frame: all state is discarded immediately (async). The next accepted row is row 0 of a new frame, and a partial row is never resumed.

Decomposition:
- Shared package conware_pkg holds:
  - state encoding for Idle/Send (shared with the upstream stage's Wait/Read style);
  - default DWIDTH/WIDTH/HEIGHT constants;
  - a helper function returning a counter width with a minimum of 1.
- No sub-module is needed: one FSM, two counters, one row register and a colour mux in a single module.

Test Plan:
- Reset then idle: hold rstn=0 for 3 cycles, release -> in_ready=0 during reset, 1 one cycle after; TVALID=0 throughout.
- Single row: WIDTH=8, HEIGHT=2, alive=0x00FFFFFF, dead=0x00000000, in_data=8'b1010_0011, TREADY=1 -> pixels FFFFFF, FFFFFF, 0, 0, 0, FFFFFF, 0, FFFFFF on consecutive cycles; TLAST=0 on all; in_ready back to 1 after the 8th beat.
- Frame TLAST: stream 2 rows (HEIGHT=2) -> TLAST=1 only on beat 16; a third row -> TLAST=0 until beat 24 (row counter wrapped).
- Backpressure: TREADY toggles 1,0,0,1,… and is held 0 for 5 cycles mid-row -> TDATA/TLAST stable while stalled; exactly 8 beats, in order, no duplicates.
- Colour latch: change alive_color to 0x12345678 after beat 3 of a row -> remaining beats of that row still use the old colour; the next row uses 0x12345678.
- Async reset mid-frame: assert rstn=0 between edges during beat 5 of row 1 -> TVALID drops to 0 immediately without waiting for clk; after release, the next row ends with TLAST on its 16th beat overall (row counter restarted at 0).

Source files
------------

// File: rtl/conware_pkg.sv
// conware_pkg: definitions shared by the conware streaming stages.
//   state_t     - two-state handshake FSM encoding. The upstream row-buffer
//                 stage uses the same encoding for its Wait/Read states.
//   DEF_*       - default pixel width, cells per row and rows per frame.
//   cnt_width() - counter width able to index 0..n-1, never less than 1 bit.
package conware_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // waiting for a row (upstream: Wait)
    ST_SEND = 1'b1   // streaming pixels (upstream: Read)
  } state_t;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_HEIGHT = 8;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buffer2axis.sv
// buffer2axis: serialises one row of cell states into an AXI-Stream of
// coloured pixels and marks the last pixel of each frame with TLAST.
//
// Ports:
//   clk, rstn      - clock; asynchronous active-low reset
//   alive_color    - pixel value for a cell bit of 1 (sampled when a row is taken)
//   dead_color     - pixel value for a cell bit of 0 (sampled when a row is taken)
//   in_data        - WIDTH-bit row, bit 0 is the first pixel sent
//   in_valid       - in_data is valid
//   in_ready       - block can take a row (registered)
//   M_AXIS_TDATA   - pixel data
//   M_AXIS_TVALID  - pixel valid (registered)
//   M_AXIS_TREADY  - sink accepts pixel
//   M_AXIS_TLAST   - last pixel of the last row of a frame
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and its data stable until that edge and
// never withdraws valid without a transfer; ready may change freely.
module buffer2axis
  import conware_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] dead_color,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST
);

  localparam int PW = cnt_width(WIDTH);
  localparam int RW = cnt_width(HEIGHT);
  localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t            state_q, state_d;
  logic              in_ready_d, tvalid_d;
  logic [PW-1:0]     pix_q;
  logic [RW-1:0]     row_cnt_q;
  logic [WIDTH-1:0]  row_q;
  logic [DWIDTH-1:0] alive_q, dead_q;

  logic accept, beat, row_done;

  assign accept   = in_valid && in_ready;
  assign beat     = M_AXIS_TVALID && M_AXIS_TREADY;
  assign row_done = beat && (pix_q == PIX_LAST);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_SEND;
      ST_SEND: if (row_done) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output logic: the handshake outputs are registered, so they are computed
  // from the next state. Reset holds both low, which is why in_ready only
  // rises on the first edge after rstn is released.
  always_comb begin
    in_ready_d = (state_d == ST_IDLE);
    tvalid_d   = (state_d == ST_SEND);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready      <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
    end else begin
      in_ready      <= in_ready_d;
      M_AXIS_TVALID <= tvalid_d;
    end
  end

  // Row and colour capture plus the pixel/row counters. Colours are sampled
  // with the row so that input colour changes only affect later rows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q     <= '0;
      alive_q   <= '0;
      dead_q    <= '0;
      pix_q     <= '0;
      row_cnt_q <= '0;
    end else begin
      if (accept) begin
        row_q   <= in_data;
        alive_q <= alive_color;
        dead_q  <= dead_color;
        pix_q   <= '0;
      end else if (beat) begin
        if (pix_q == PIX_LAST) begin
          pix_q <= '0;
          // Explicit wrap: HEIGHT need not be a power of two.
          if (row_cnt_q == ROW_LAST) row_cnt_q <= '0;
          else                       row_cnt_q <= row_cnt_q + 1'b1;
        end else begin
          pix_q <= pix_q + 1'b1;
        end
      end
    end
  end

  // Pixel counter and row register only change on a beat or a new row,
  // so TDATA/TLAST stay stable while the sink stalls.
  assign M_AXIS_TDATA = M_AXIS_TVALID ? (row_q[pix_q] ? alive_q : dead_q) : '0;
  assign M_AXIS_TLAST = M_AXIS_TVALID && (pix_q == PIX_LAST) && (row_cnt_q == ROW_LAST);

endmodule

// File: tb/tb_buffer2axis.sv
module tb_buffer2axis;

  localparam int DW = 32;
  localparam int W  = 8;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] alive_color;
  logic [DW-1:0] dead_color;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  always #5 clk = ~clk;

  buffer2axis #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .alive_color   (alive_color),
    .dead_color    (dead_color),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TLAST  (tlast)
  );

  // Expected beats, {tlast, tdata}, in stream order.
  logic [DW:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int rows_acc = 0;  // rows accepted since the last reset

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Offer a row at a negedge once in_ready is seen; the reference model
  // expands it into pixels using the colours applied at acceptance.
  task automatic push_row(input logic [W-1:0] data);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      timeout_fail("in_ready_wait");
      return;
    end
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < W; i++)
      exp_q.push_back({(i == W - 1) && ((rows_acc % H) == H - 1),
                       data[i] ? alive_color : dead_color});
    rows_acc++;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Consume one row. mode 0: TREADY always 1. mode 1: random TREADY with a
  // 5-cycle stall after beat 4. chg_at > 0: set alive_color to chg_val after
  // that many beats. abort_at > 0: return after that many beats.
  task automatic drain_row(input int mode, input int chg_at, input logic [DW-1:0] chg_val,
                           input int abort_at);
    int beats, cyc, hold;
    bit stalled, did_long, changed;
    logic [DW-1:0] snap_d;
    logic snap_l;
    logic [DW:0] e;
    beats = 0; cyc = 0; hold = 0;
    stalled = 0; did_long = 0; changed = 0;
    snap_d = '0; snap_l = 1'b0;
    while (beats < W && cyc < 300) begin
      if (stalled) begin
        check("stall_tdata", 64'(tdata), 64'(snap_d));
        check("stall_tlast", 64'(tlast), 64'(snap_l));
      end
      check("tvalid_in_row", 64'(tvalid), 64'd1);
      check("in_ready_in_row", 64'(in_ready), 64'd0);
      if (mode == 0) tready = 1'b1;
      else begin
        if (beats == 4 && !did_long) begin
          hold = 5;
          did_long = 1;
        end
        if (hold > 0) begin
          tready = 1'b0;
          hold--;
        end else tready = 1'($urandom_range(0, 1));
      end
      stalled = (tvalid === 1'b1) && !tready;
      snap_d  = tdata;
      snap_l  = tlast;
      if (tvalid === 1'b1 && tready) begin
        if (exp_q.size() == 0) timeout_fail("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          check("beat_tdata", 64'(tdata), 64'(e[DW-1:0]));
          check("beat_tlast", 64'(tlast), 64'(e[DW]));
        end
        beats++;
      end
      @(negedge clk);
      cyc++;
      if (chg_at > 0 && beats == chg_at && !changed) begin
        alive_color = chg_val;
        changed = 1;
      end
      if (abort_at > 0 && beats == abort_at) return;
    end
    if (beats < W) begin
      timeout_fail("row_drain");
      return;
    end
    check("in_ready_after_row", 64'(in_ready), 64'd1);
    check("tvalid_after_row", 64'(tvalid), 64'd0);
  endtask

  initial begin
    alive_color = 32'h00FF_FFFF;
    dead_color  = 32'h0000_0000;
    in_data     = '0;
    in_valid    = 1'b0;
    tready      = 1'b1;

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_tvalid", 64'(tvalid), 64'd0);
      check("rst_tdata", 64'(tdata), 64'd0);
      check("rst_tlast", 64'(tlast), 64'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    check("tvalid_idle", 64'(tvalid), 64'd0);

    // Single known row, then a second to complete the frame (TLAST on beat 16).
    push_row(8'b1010_0011);
    drain_row(0, 0, '0, 0);
    push_row(W'($urandom));
    drain_row(0, 0, '0, 0);

    // Third row: row counter wrapped, backpressure with a long stall.
    push_row(W'($urandom));
    drain_row(1, 0, '0, 0);

    // Colour change mid-row: affects only the following row.
    push_row(W'($urandom) | 8'hF0);
    drain_row(0, 3, 32'h1234_5678, 0);
    check("alive_input_changed", 64'(alive_color), 64'h1234_5678);
    push_row(W'($urandom) | 8'h0F);
    drain_row(0, 0, '0, 0);

    // Random rows, colours and backpressure.
    for (int r = 0; r < 6; r++) begin
      alive_color = $urandom;
      dead_color  = $urandom;
      push_row(W'($urandom));
      drain_row(1, 0, '0, 0);
    end

    // Line up so the next accepted row is row 1 of its frame.
    if ((rows_acc % H) != 1) begin
      push_row(W'($urandom));
      drain_row(0, 0, '0, 0);
    end

    // Async reset during beat 5 of row 1.
    tready = 1'b1;
    push_row(W'($urandom));
    drain_row(0, 0, '0, 5);
    @(posedge clk);
    #2;
    check("tvalid_before_async_rst", 64'(tvalid), 64'd1);
    rstn = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(tvalid), 64'd0);
    check("async_rst_tlast", 64'(tlast), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    rows_acc = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_async_rst", 64'(in_ready), 64'd1);

    // New frame: TLAST on the 16th beat after the reset.
    push_row(W'($urandom));
    drain_row(0, 0, '0, 0);
    push_row(W'($urandom));
    drain_row(1, 0, '0, 0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
